// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the sequential mult/div unit
package muldiv_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ITERS  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } stateT;

  // Divide-by-zero result: LO is filled with this bit, HI returns the dividend.
  localparam logic DIV0_LO_FILL     = 1'b1;
  localparam logic DIV0_HI_DIVIDEND = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply step or one restoring divide step
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              isDivOp,
  input  logic [DATA_W-1:0] hiIn,
  input  logic [DATA_W-1:0] loIn,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] hiOut,
  output logic [DATA_W-1:0] loOut
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            fits;

  // Multiply: add multiplicand when the multiplier LSB is set, then shift the
  // whole {hi,lo} product right. Divide: shift the next dividend bit into the
  // partial remainder and keep the subtraction only if it does not go negative.
  always_comb begin
    sum     = {1'b0, hiIn} + (loIn[0] ? {1'b0, operand} : '0);
    shifted = {hiIn, loIn[DATA_W-1]};
    diff    = shifted - {1'b0, operand};
    fits    = ~diff[DATA_W];
    if (isDivOp) begin
      hiOut = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      loOut = {loIn[DATA_W-2:0], fits};
    end else begin
      hiOut = sum[DATA_W:1];
      loOut = {sum[0], loIn[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle mult/div unit with HI/LO registers and stall
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ITERS  = DEFAULT_ITERS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              isMult,
  input  logic              isDiv,
  input  logic              isSigned,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              isMthi,
  input  logic              isMtlo,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              isMfhi,
  input  logic              isMflo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o,
  output logic              stall_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(ITERS);

  stateT             state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] accHi, accLo, bReg;
  logic [DATA_W-1:0] hiReg, loReg;
  logic              resSign, remSign, divZero, opDiv;
  logic              busyReg, doneReg;

  logic              rsNeg, rtNeg;
  logic [DATA_W-1:0] rsMag, rtMag;
  logic [DATA_W-1:0] stepHi, stepLo;
  logic              stepDiv;

  // Operand magnitudes; sign handling is deferred to the FIX cycle.
  always_comb begin
    rsNeg = isSigned & rs_i[DATA_W-1];
    rtNeg = isSigned & rt_i[DATA_W-1];
    rsMag = rsNeg ? -rs_i : rs_i;
    rtMag = rtNeg ? -rt_i : rt_i;
  end

  assign stepDiv = (state == DIV);

  muldiv_step #(.DATA_W(DATA_W)) uStep (
    .isDivOp (stepDiv),
    .hiIn    (accHi),
    .loIn    (accLo),
    .operand (bReg),
    .hiOut   (stepHi),
    .loOut   (stepLo)
  );

  // FSM, iteration counter, working registers and architectural HI/LO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      bReg    <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      resSign <= 1'b0;
      remSign <= 1'b0;
      divZero <= 1'b0;
      opDiv   <= 1'b0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (isMult || isDiv) begin
            accHi   <= '0;
            accLo   <= isMult ? rtMag : rsMag;
            bReg    <= isMult ? rsMag : rtMag;
            resSign <= rsNeg ^ rtNeg;
            remSign <= rsNeg;
            opDiv   <= ~isMult;
            cnt     <= CNT_W'(ITERS - 1);
            busyReg <= 1'b1;
            if (isMult) begin
              divZero <= 1'b0;
              state   <= MUL;
            end else if (rt_i == '0) begin
              divZero <= 1'b1;
              state   <= FIX;
            end else begin
              divZero <= 1'b0;
              state   <= DIV;
            end
          end else begin
            if (isMthi) hiReg <= wdata_i;
            if (isMtlo) loReg <= wdata_i;
          end
        end
        MUL, DIV: begin
          accHi <= stepHi;
          accLo <= stepLo;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (divZero) begin
            hiReg <= (DIV0_HI_DIVIDEND && remSign) ? -accLo : accLo;
            loReg <= {DATA_W{DIV0_LO_FILL}};
          end else if (opDiv) begin
            hiReg <= remSign ? -accHi : accHi;
            loReg <= resSign ? -accLo : accLo;
          end else begin
            {hiReg, loReg} <= resSign ? -{accHi, accLo} : {accHi, accLo};
          end
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign hi_o    = hiReg;
  assign lo_o    = loReg;
  assign busy_o  = busyReg;
  assign done_o  = doneReg;
  assign stall_o = busyReg & (isMult | isDiv | isMfhi | isMflo | isMthi | isMtlo);

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand, HI and LO width.
REQ-002 SHALL have parameter ITERS, default 32, giving the number of iteration cycles per mult/div; it SHALL equal DATA_W.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port isMult  in  1  EX-stage mult/multu start request.
REQ-006 SHALL have port isDiv  in  1  EX-stage div/divu start request.
REQ-007 SHALL have port isSigned  in  1  signed operation (mult/div) when 1, unsigned when 0.
REQ-008 SHALL have port rs_i  in  DATA_W  multiplicand or dividend.
REQ-009 SHALL have port rt_i  in  DATA_W  multiplier or divisor.
REQ-010 SHALL have port isMthi  in  1  write wdata_i to HI.
REQ-011 SHALL have port isMtlo  in  1  write wdata_i to LO.
REQ-012 SHALL have port wdata_i  in  DATA_W  mthi/mtlo data.
REQ-013 SHALL have port isMfhi  in  1  EX-stage read of HI.
REQ-014 SHALL have port isMflo  in  1  EX-stage read of LO.
REQ-015 SHALL have port hi_o  out  DATA_W  architectural HI.
REQ-016 SHALL have port lo_o  out  DATA_W  architectural LO.
REQ-017 SHALL have port busy_o  out  1  operation in progress.
REQ-018 SHALL have port stall_o  out  1  hold-EX request to the hazard unit.
REQ-019 SHALL have port done_o  out  1  one-cycle pulse marking the first cycle new HI/LO are visible.

Function
REQ-020 SHALL implement FSM states IDLE, MUL, DIV and FIX; busy_o SHALL be 1 in MUL, DIV and FIX.
REQ-021 In IDLE, isMult SHALL latch |rs_i|, |rt_i| (magnitudes only when isSigned=1), the result sign and the remainder sign, load the counter with ITERS-1, and go to MUL.
REQ-022 In IDLE, isDiv SHALL latch the same information and go to DIV; if rt_i==0 it SHALL go directly to FIX with a div-by-zero flag set.
REQ-023 If isMult and isDiv are both asserted, isMult SHALL win.
REQ-024 MUL SHALL perform one shift-add step per cycle and DIV one restoring shift-subtract step per cycle; the counter decrements each step, and on a step with count 0 the FSM SHALL go to FIX.
REQ-025 FIX SHALL apply two's-complement negation where the latched signs require it, write HI/LO at the end of the cycle, and return to IDLE.
REQ-026 Latency: with start sampled at edge E0, iterations occupy cycles 1..32, FIX is cycle 33, and cycle 34 shows new HI/LO with busy_o=0 and done_o=1.
REQ-027 Divide-by-zero SHALL give LO=all ones and HI=original rs_i, visible in cycle 2 after start.
REQ-028 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-029 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-030 In IDLE, isMthi/isMtlo SHALL write HI/LO at the next edge.
REQ-031 isMthi/isMtlo SHALL be ignored when isMult or isDiv is asserted in the same cycle.
REQ-032 stall_o SHALL equal busy_o & (isMult | isDiv | isMfhi | isMflo | isMthi | isMtlo), and SHALL be combinational.
REQ-033 Start, mt and mf requests SHALL be ignored while busy_o=1; the pipeline re-presents them after stall_o falls.
REQ-034 hi_o/lo_o SHALL hold their previous values throughout MUL, DIV and FIX.
REQ-035 done_o SHALL be registered.

Reset
REQ-036 RST SHALL force IDLE, HI=0, LO=0, counter=0, busy_o=0 and done_o=0 at the next edge, including when asserted mid-operation; the in-flight result SHALL be discarded.
REQ-037 RST SHALL take priority over every request in the same cycle.

Structure
REQ-038 Package muldiv_pkg SHALL hold the state encoding, DATA_W and ITERS defaults, and the div-by-zero constants.
REQ-039 One sub-module, muldiv_step, SHALL contain the combinational single-iteration add/shift and subtract/restore logic; the FSM, counter and HI/LO registers SHALL stay in muldiv_seq.

Verification
REQ-040 multu 0xFFFFFFFF x 0xFFFFFFFF -> cycle 34: HI=0xFFFFFFFE, LO=0x00000001, done_o=1.
REQ-041 mult -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-042 divu 5 / 0 -> cycle 2: LO=0xFFFFFFFF, HI=0x00000005; busy_o high only in cycle 1.
REQ-043 isMfhi held from cycle 5 of a mult -> stall_o=1 through cycle 33, 0 in cycle 34; second isMult during busy -> ignored, HI/LO unchanged.
REQ-044 RST at cycle 10 of a mult -> next cycle busy_o=0, HI=LO=0, done_o never pulses.
REQ-045 mthi 0x12345678 in IDLE -> next cycle hi_o=0x12345678; isMthi together with isMult -> mult starts, HI not written by the mthi.
